// File: rtl/input_port_route_buffer_if.sv
// input_port_route_buffer_if: link, arbiter and crossbar signals of one router input port
interface input_port_route_buffer_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  logic [DATA_W-1:0]        in_flit;
  logic                     in_valid;
  logic                     in_ready;
  logic [4:0]               req_out;
  logic [4:0]               gnt_in;
  logic [DATA_W-1:0]        out_flit;
  logic                     out_valid;
  logic [4:0]               out_port;
  logic [$clog2(DEPTH):0]   occupancy;
  modport slave (
    input  in_flit, in_valid, gnt_in,
    output in_ready, req_out, out_flit, out_valid, out_port, occupancy
  );
  modport master (
    output in_flit, in_valid, gnt_in,
    input  in_ready, req_out, out_flit, out_valid, out_port, occupancy
  );
endinterface

// File: rtl/input_port_route_buffer.sv
// input_port_route_buffer: per-input flit FIFO with XY route request and registered crossbar output
module input_port_route_buffer #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int X_W     = 1,
  parameter int Y_W     = 1,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0
) (
  input logic                       clk,
  input logic                       rst,
  input_port_route_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [X_W-1:0] LX = X_W'(LOCAL_X);
  localparam logic [Y_W-1:0] LY = Y_W'(LOCAL_Y);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0]       count;
  logic [DATA_W-1:0] head, nxt;
  logic [4:0]        req_q, req_next, port_q;
  logic [DATA_W-1:0] flit_q;
  logic              valid_q, push, pop, empty, ready;
  function automatic logic [4:0] route(input logic [X_W-1:0] dx, input logic [Y_W-1:0] dy);
    return dx > LX ? 5'b00100 :
           dx < LX ? 5'b10000 :
           dy > LY ? 5'b01000 :
           dy < LY ? 5'b00010 : 5'b00001;
  endfunction
  // Handshake decode and next request; on a pop the request looks ahead to the
  // following entry so a held grant streams back-to-back flits without a bubble.
  always_comb begin
    rd_nxt   = rd_ptr + AW'(1);
    head     = mem[rd_ptr];
    nxt      = mem[rd_nxt];
    empty    = count == '0;
    ready    = count != (AW+1)'(DEPTH);
    push     = bus.in_valid && ready;
    pop      = |(req_q & bus.gnt_in);
    req_next = pop ? (count > (AW+1)'(1) ? route(nxt[X_W-1:0], nxt[X_W+Y_W-1:X_W]) : 5'b0)
                   : (empty ? 5'b0 : route(head[X_W-1:0], head[X_W+Y_W-1:X_W]));
  end
  // Flit storage; reads are gated by occupancy so the array needs no reset
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.in_flit;
  // Pointers, occupancy, registered request and crossbar output stage
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      req_q   <= '0;
      flit_q  <= '0;
      port_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_nxt;
      count   <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      req_q   <= req_next;
      valid_q <= pop;
      if (pop) begin
        flit_q <= head;
        port_q <= req_q;
      end
    end
  assign bus.in_ready  = ready;
  assign bus.req_out   = req_q;
  assign bus.out_flit  = flit_q;
  assign bus.out_valid = valid_q;
  assign bus.out_port  = port_q;
  assign bus.occupancy = count;
endmodule
